axi4_simple_master: RTL and testbench
=====================================

# axi4_simple_master

AXI4 initiator that turns single-command requests into one AXI4 INCR burst each, driving the slave ports of memory subsystems such as `axi4_l1_mem_subsystem`. It is used by bench-less bring-up logic, DMA front-ends and processor-side adapters to issue reads and writes. Write data arrives on a valid/ready stream, and read data leaves on one. One transaction is outstanding at a time.

## Interface

Parameters:
- AXI4_ADDRESS_WIDTH, 20, byte address width
- AXI4_DATA_WIDTH, 32, data width; legal values 32 or 64
- AXI4_ID_WIDTH, 2, width of the AXI ID fields

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
- Command channel:
  - cmd_valid  in  1  command present
  - cmd_ready  out  1  command accepted on valid&ready
  - cmd_write  in  1  1 = write, 0 = read
  - cmd_addr  in  AXI4_ADDRESS_WIDTH  start address, size-aligned
  - cmd_len  in  8  beats minus 1 (AXI LEN)
  - cmd_id  in  AXI4_ID_WIDTH  ID driven on AW or AR
- Write data stream:
  - wdat_valid  in  1  write data present
  - wdat_ready  out  1  write data accepted
  - wdat_data  in  AXI4_DATA_WIDTH  write beat data
- Read data stream:
  - rdat_valid  out  1  read data present
  - rdat_ready  in  1  read data accepted
  - rdat_data  out  AXI4_DATA_WIDTH  read beat data
  - rdat_last  out  1  final beat of the burst
- Response:
  - rsp_valid  out  1  one-cycle pulse when the transaction completes
  - rsp_write  out  1  completed transaction was a write
  - rsp_resp  out  2  final response code
- AXI4 master: the full AW/W/B/AR/R master port set generated by `AXI4_IF_MASTER_PORTS(m, AXI4_ADDRESS_WIDTH, AXI4_DATA_WIDTH, AXI4_ID_WIDTH)`, with signal names m_AWADDR … m_RREADY.

## Operation

**State machine.** States are IDLE, AW, W, B, AR, R, DONE.
- IDLE:
  - cmd_ready=1.
  - When a command is accepted, latch addr, len, id and write.
  - Go to AW if cmd_write is set, otherwise AR.
- AW:
  - AWVALID=1 with AWADDR, AWLEN, AWID, AWSIZE=log2(DATA_WIDTH/8), AWBURST=INCR(2b01).
  - AWLOCK=0, AWCACHE=0, AWPROT=0, AWQOS=0, AWREGION=0.
  - On AWREADY, go to W.
- W:
  - wdat_ready = WREADY. WVALID = wdat_valid. WDATA = wdat_data. WSTRB is all ones.
  - WLAST is asserted when the beat counter equals the latched len.
  - On the last beat handshake, go to B.
- B:
  - BREADY=1.
  - On BVALID, capture BRESP and go to DONE.
- AR:
  - Same field rules as AW, on the AR channel.
  - On ARREADY, go to R.
- R:
  - RREADY = rdat_ready. rdat_valid = RVALID. rdat_data = RDATA. rdat_last = RLAST.
  - Response capture: keep the first non-OKAY RRESP; otherwise keep OKAY.
  - On the RLAST handshake, go to DONE.
- DONE:
  - rsp_valid=1 for one cycle with rsp_write and rsp_resp.
  - Return to IDLE.

**Beat counter.**
- 8 bits, cleared on command accept.
- Increments on each W (or R) handshake.
- No wrap is possible because len ≤ 255.

**Boundary conditions.**
- A burst whose address range crosses a 4 KB boundary is illegal. A simulation assertion fires; no splitting is done.
- RLAST arriving before the counter reaches len, or the counter reaching len without RLAST, fires an assertion. The FSM still exits on RLAST.
- Reset mid-transaction: all outputs return to reset values immediately and the FSM goes to IDLE. The downstream slave is reset on the same rst_n.
- cmd_valid while busy: cmd_ready=0, and the command is held by the source.

## Timing

- Reset values:
  - All outputs are 0: valids, readies, m_* address/data/control, rsp_*, rdat_*.
  - Exception: cmd_ready=1 in IDLE after reset.
- Latency:
  - Command accept to AWVALID/ARVALID: 1 cycle.
  - BVALID or the final R handshake to rsp_valid: 1 cycle.
  - rsp_valid to the next cmd_ready: 1 cycle.
- W and R paths are combinational pass-throughs, giving full throughput of 1 beat per cycle.
- AXI rule: once asserted, AWVALID, ARVALID and WVALID hold with stable payload until READY. WVALID stability is inherited from wdat_valid; the source obeys the same rule.
- All state, address, ID and response registers update on the rising edge of clk_i only.

## Structure

- Package `axi4_master_pkg`:
  - state enum (IDLE, AW, W, B, AR, R, DONE)
  - burst constants (FIXED, INCR, WRAP)
  - response constants (OKAY, EXOKAY, SLVERR, DECERR)
- Single module; no sub-module needed.
- The testbench top wraps it with `axi4_if` and connects it to `axi4_l1_mem_subsystem`.

## Test plan

- **Single write.** Write addr=0x100, len=0, data=0xDEADBEEF. Expect: one AW with AWLEN=0, one W with WLAST=1, then rsp_valid with resp=OKAY and rsp_write=1.
- **Burst write then read.** Write addr=0x200, len=7, data 0..7; then read the same address and length. Expect: 8 rdat beats 0..7, rdat_last only on beat 7, resp=OKAY.
- **Backpressure.** Hold rdat_ready low for 3 cycles mid-burst and toggle wdat_valid. Expect: no lost or duplicated beats and RREADY tracking rdat_ready.
- **Error response.** The slave returns SLVERR on beat 2 of a 4-beat read and OKAY on the rest. Expect: rsp_resp=2'b10.
- **Reset mid-burst.** Assert rst_n low during the W phase. Expect: all outputs 0 the same cycle, and cmd_ready=1 after reset is released.
- **Busy and 4 KB assertion.** A command presented while in B gets cmd_ready=0 until IDLE. A command with addr=0xFFC, len=1 fires the 4 KB assertion.

Source files
------------

// File: rtl/axi4_master_pkg.sv
// Shared types and constants for the single-outstanding AXI4 burst master.
// Also holds the 4 KB crossing helper used on command accept.
package axi4_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

    // True when a burst starting at this in-page offset runs past the 4 KB page end.
    function automatic logic crosses_4k(input logic [11:0] offset,
                                        input logic [7:0]  len,
                                        input logic [2:0]  size);
        logic [16:0] span;
        span = (17'(len) + 17'd1) << size;
        return (17'(offset) + span) > 17'd4096;
    endfunction

endpackage

// File: rtl/axi4_simple_master.sv
// AXI4 initiator: one command becomes one INCR burst, one transaction in flight.
// W and R beats pass straight through between the streams and the AXI port.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// AW      | write address valid, waiting for AWREADY
// W       | write beats pass through from the wdat stream
// B       | waiting for the write response
// AR      | read address valid, waiting for ARREADY
// R       | read beats pass through to the rdat stream
// DONE    | one-cycle rsp_valid pulse
module axi4_simple_master
    import axi4_master_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 20,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_n,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [AXI4_ADDRESS_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                      cmd_len,
    input  logic [AXI4_ID_WIDTH-1:0]        cmd_id,

    input  logic                            wdat_valid,
    output logic                            wdat_ready,
    input  logic [AXI4_DATA_WIDTH-1:0]      wdat_data,

    output logic                            rdat_valid,
    input  logic                            rdat_ready,
    output logic [AXI4_DATA_WIDTH-1:0]      rdat_data,
    output logic                            rdat_last,

    output logic                            rsp_valid,
    output logic                            rsp_write,
    output logic [1:0]                      rsp_resp,

    output logic [AXI4_ID_WIDTH-1:0]        m_AWID,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   m_AWADDR,
    output logic [7:0]                      m_AWLEN,
    output logic [2:0]                      m_AWSIZE,
    output logic [1:0]                      m_AWBURST,
    output logic                            m_AWLOCK,
    output logic [3:0]                      m_AWCACHE,
    output logic [2:0]                      m_AWPROT,
    output logic [3:0]                      m_AWQOS,
    output logic [3:0]                      m_AWREGION,
    output logic                            m_AWVALID,
    input  logic                            m_AWREADY,

    output logic [AXI4_DATA_WIDTH-1:0]      m_WDATA,
    output logic [AXI4_DATA_WIDTH/8-1:0]    m_WSTRB,
    output logic                            m_WLAST,
    output logic                            m_WVALID,
    input  logic                            m_WREADY,

    input  logic [AXI4_ID_WIDTH-1:0]        m_BID,
    input  logic [1:0]                      m_BRESP,
    input  logic                            m_BVALID,
    output logic                            m_BREADY,

    output logic [AXI4_ID_WIDTH-1:0]        m_ARID,
    output logic [AXI4_ADDRESS_WIDTH-1:0]   m_ARADDR,
    output logic [7:0]                      m_ARLEN,
    output logic [2:0]                      m_ARSIZE,
    output logic [1:0]                      m_ARBURST,
    output logic                            m_ARLOCK,
    output logic [3:0]                      m_ARCACHE,
    output logic [2:0]                      m_ARPROT,
    output logic [3:0]                      m_ARQOS,
    output logic [3:0]                      m_ARREGION,
    output logic                            m_ARVALID,
    input  logic                            m_ARREADY,

    input  logic [AXI4_ID_WIDTH-1:0]        m_RID,
    input  logic [AXI4_DATA_WIDTH-1:0]      m_RDATA,
    input  logic [1:0]                      m_RRESP,
    input  logic                            m_RLAST,
    input  logic                            m_RVALID,
    output logic                            m_RREADY
);

    localparam logic [2:0] AXSIZE = axi_size(AXI4_DATA_WIDTH);

    state_e                          state_q;
    logic [AXI4_ADDRESS_WIDTH-1:0]   addr_q;
    logic [7:0]                      len_q;
    logic [AXI4_ID_WIDTH-1:0]        id_q;
    logic                            write_q;
    logic [7:0]                      cnt_q;
    logic [1:0]                      resp_q;

    logic in_aw, in_w, in_b, in_ar, in_r, in_done;
    logic w_hs, r_hs, w_last;
    logic cross_4k;

    assign in_aw   = (state_q == ST_AW);
    assign in_w    = (state_q == ST_W);
    assign in_b    = (state_q == ST_B);
    assign in_ar   = (state_q == ST_AR);
    assign in_r    = (state_q == ST_R);
    assign in_done = (state_q == ST_DONE);

    assign w_last   = in_w && (cnt_q == len_q);
    assign w_hs     = m_WVALID && m_WREADY;
    assign r_hs     = m_RVALID && m_RREADY;
    assign cross_4k = crosses_4k(cmd_addr[11:0], cmd_len, AXSIZE);

    assign cmd_ready  = (state_q == ST_IDLE);

    assign m_AWID     = in_aw ? id_q   : '0;
    assign m_AWADDR   = in_aw ? addr_q : '0;
    assign m_AWLEN    = in_aw ? len_q  : '0;
    assign m_AWSIZE   = in_aw ? AXSIZE : '0;
    assign m_AWBURST  = in_aw ? BURST_INCR : '0;
    assign m_AWLOCK   = 1'b0;
    assign m_AWCACHE  = '0;
    assign m_AWPROT   = '0;
    assign m_AWQOS    = '0;
    assign m_AWREGION = '0;
    assign m_AWVALID  = in_aw;

    assign m_ARID     = in_ar ? id_q   : '0;
    assign m_ARADDR   = in_ar ? addr_q : '0;
    assign m_ARLEN    = in_ar ? len_q  : '0;
    assign m_ARSIZE   = in_ar ? AXSIZE : '0;
    assign m_ARBURST  = in_ar ? BURST_INCR : '0;
    assign m_ARLOCK   = 1'b0;
    assign m_ARCACHE  = '0;
    assign m_ARPROT   = '0;
    assign m_ARQOS    = '0;
    assign m_ARREGION = '0;
    assign m_ARVALID  = in_ar;

    // Beat paths are gated by state so the bus is quiet outside W and R.
    assign m_WVALID   = in_w && wdat_valid;
    assign m_WDATA    = in_w ? wdat_data : '0;
    assign m_WSTRB    = in_w ? '1 : '0;
    assign m_WLAST    = w_last;
    assign wdat_ready = in_w && m_WREADY;

    assign m_BREADY   = in_b;

    assign m_RREADY   = in_r && rdat_ready;
    assign rdat_valid = in_r && m_RVALID;
    assign rdat_data  = in_r ? m_RDATA : '0;
    assign rdat_last  = in_r && m_RLAST;

    assign rsp_valid  = in_done;
    assign rsp_write  = in_done && write_q;
    assign rsp_resp   = in_done ? resp_q : '0;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        assert (!cross_4k)
                            else $warning("axi4_simple_master: burst at %0h len %0d crosses a 4KB page",
                                          cmd_addr, cmd_len);
                        addr_q  <= cmd_addr;
                        len_q   <= cmd_len;
                        id_q    <= cmd_id;
                        write_q <= cmd_write;
                        cnt_q   <= '0;
                        resp_q  <= RESP_OKAY;
                        state_q <= cmd_write ? ST_AW : ST_AR;
                    end
                end
                ST_AW: if (m_AWREADY) state_q <= ST_W;
                ST_W: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (w_last) state_q <= ST_B;
                    end
                end
                ST_B: begin
                    if (m_BVALID) begin
                        assert (m_BID == id_q) else $error("axi4_simple_master: BID does not match AWID");
                        resp_q  <= m_BRESP;
                        state_q <= ST_DONE;
                    end
                end
                ST_AR: if (m_ARREADY) state_q <= ST_R;
                ST_R: begin
                    if (r_hs) begin
                        assert (m_RLAST == (cnt_q == len_q))
                            else $error("axi4_simple_master: RLAST at beat %0d, expected at %0d", cnt_q, len_q);
                        assert (m_RID == id_q) else $error("axi4_simple_master: RID does not match ARID");
                        cnt_q <= cnt_q + 8'd1;
                        // First error response wins; later OKAY beats do not clear it.
                        if (resp_q == RESP_OKAY) resp_q <= m_RRESP;
                        if (m_RLAST) state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_simple_master.sv
// Directed bench for axi4_simple_master with a small in-bench AXI4 memory slave.
module tb_axi4_simple_master;
    import axi4_master_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;
    localparam int IW = 2;

    logic clk_i = 1'b0;
    logic rst_n;
    always #5 clk_i = ~clk_i;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [IW-1:0] cmd_id;
    logic          wdat_valid, wdat_ready;
    logic [DW-1:0] wdat_data;
    logic          rdat_valid, rdat_ready, rdat_last;
    logic [DW-1:0] rdat_data;
    logic          rsp_valid, rsp_write;
    logic [1:0]    rsp_resp;

    logic [IW-1:0] m_AWID, m_ARID, m_BID, m_RID;
    logic [AW-1:0] m_AWADDR, m_ARADDR;
    logic [7:0]    m_AWLEN, m_ARLEN;
    logic [2:0]    m_AWSIZE, m_ARSIZE, m_AWPROT, m_ARPROT;
    logic [1:0]    m_AWBURST, m_ARBURST, m_BRESP, m_RRESP;
    logic          m_AWLOCK, m_ARLOCK;
    logic [3:0]    m_AWCACHE, m_ARCACHE, m_AWQOS, m_ARQOS, m_AWREGION, m_ARREGION;
    logic          m_AWVALID, m_AWREADY, m_ARVALID, m_ARREADY;
    logic [DW-1:0] m_WDATA, m_RDATA;
    logic [DW/8-1:0] m_WSTRB;
    logic          m_WLAST, m_WVALID, m_WREADY;
    logic          m_BVALID, m_BREADY;
    logic          m_RLAST, m_RVALID, m_RREADY;

    axi4_simple_master #(
        .AXI4_ADDRESS_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)
    ) dut (
        .clk_i(clk_i), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
        .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data), .rdat_last(rdat_last),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_resp(rsp_resp),
        .m_AWID(m_AWID), .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
        .m_AWBURST(m_AWBURST), .m_AWLOCK(m_AWLOCK), .m_AWCACHE(m_AWCACHE), .m_AWPROT(m_AWPROT),
        .m_AWQOS(m_AWQOS), .m_AWREGION(m_AWREGION), .m_AWVALID(m_AWVALID), .m_AWREADY(m_AWREADY),
        .m_WDATA(m_WDATA), .m_WSTRB(m_WSTRB), .m_WLAST(m_WLAST), .m_WVALID(m_WVALID), .m_WREADY(m_WREADY),
        .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BVALID(m_BVALID), .m_BREADY(m_BREADY),
        .m_ARID(m_ARID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
        .m_ARBURST(m_ARBURST), .m_ARLOCK(m_ARLOCK), .m_ARCACHE(m_ARCACHE), .m_ARPROT(m_ARPROT),
        .m_ARQOS(m_ARQOS), .m_ARREGION(m_ARREGION), .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY),
        .m_RID(m_RID), .m_RDATA(m_RDATA), .m_RRESP(m_RRESP), .m_RLAST(m_RLAST),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY)
    );

    // Memory slave: always-ready address/data, B gated by b_en, optional SLVERR on one R beat.
    logic [31:0]   mem [0:1023];
    logic [9:0]    wptr, rptr;
    logic          bvalid_q, rvalid_q;
    logic [IW-1:0] bid_q, rid_q;
    logic [7:0]    rleft, rbeat;
    logic          b_en;
    int            err_beat;

    assign m_AWREADY = 1'b1;
    assign m_ARREADY = 1'b1;
    assign m_WREADY  = 1'b1;
    assign m_BVALID  = bvalid_q && b_en;
    assign m_BRESP   = RESP_OKAY;
    assign m_BID     = bid_q;
    assign m_RVALID  = rvalid_q;
    assign m_RDATA   = mem[rptr];
    assign m_RLAST   = (rleft == 8'd0);
    assign m_RRESP   = (int'(rbeat) == err_beat) ? RESP_SLVERR : RESP_OKAY;
    assign m_RID     = rid_q;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0; rptr <= '0; bvalid_q <= 1'b0; rvalid_q <= 1'b0;
            bid_q <= '0; rid_q <= '0; rleft <= '0; rbeat <= '0;
        end else begin
            if (m_AWVALID && m_AWREADY) begin
                wptr  <= m_AWADDR[11:2];
                bid_q <= m_AWID;
            end
            if (m_WVALID && m_WREADY) begin
                wptr <= wptr + 10'd1;
                if (m_WLAST) bvalid_q <= 1'b1;
            end
            if (m_BVALID && m_BREADY) bvalid_q <= 1'b0;
            if (m_ARVALID && m_ARREADY) begin
                rvalid_q <= 1'b1;
                rptr     <= m_ARADDR[11:2];
                rleft    <= m_ARLEN;
                rbeat    <= '0;
                rid_q    <= m_ARID;
            end else if (rvalid_q && m_RREADY) begin
                if (rleft == 8'd0) rvalid_q <= 1'b0;
                else begin
                    rptr  <= rptr + 10'd1;
                    rleft <= rleft - 8'd1;
                    rbeat <= rbeat + 8'd1;
                end
            end
        end
    end

    always @(posedge clk_i) begin
        if (m_WVALID && m_WREADY) mem[wptr] <= m_WDATA;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [IW-1:0] id, input string tag);
        int cyc = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_id = id;
        #1;
        while (!cmd_ready && cyc < 50) begin
            @(negedge clk_i); #1; cyc++;
        end
        chk({tag, "_accept"}, cmd_ready, 1);
        @(negedge clk_i);
        cmd_valid = 1'b0;
        #1;
        chk({tag, "_busy"}, cmd_ready, 0);
        if (w) begin
            chk({tag, "_awvalid"}, m_AWVALID, 1);
            chk({tag, "_awaddr"},  m_AWADDR, a);
            chk({tag, "_awlen"},   m_AWLEN, l);
            chk({tag, "_awid"},    m_AWID, id);
            chk({tag, "_awsize"},  m_AWSIZE, 3'd2);
            chk({tag, "_awburst"}, m_AWBURST, 2'b01);
        end else begin
            chk({tag, "_arvalid"}, m_ARVALID, 1);
            chk({tag, "_araddr"},  m_ARADDR, a);
            chk({tag, "_arlen"},   m_ARLEN, l);
            chk({tag, "_arid"},    m_ARID, id);
            chk({tag, "_arsize"},  m_ARSIZE, 3'd2);
            chk({tag, "_arburst"}, m_ARBURST, 2'b01);
        end
    endtask

    task automatic write_beats(input int n, input logic [31:0] base, input bit gaps, input string tag);
        for (int i = 0; i < n; i++) begin
            int cyc = 0;
            if (gaps && i[0]) begin
                wdat_valid = 1'b0;
                #1;
                chk({tag, "_gap_wvalid"}, m_WVALID, 0);
                @(negedge clk_i);
            end
            wdat_valid = 1'b1;
            wdat_data  = base + 32'(i);
            #1;
            while (!wdat_ready && cyc < 20) begin
                @(negedge clk_i); #1; cyc++;
            end
            chk({tag, "_wready"}, wdat_ready, 1);
            chk({tag, "_wdata"},  m_WDATA, base + 32'(i));
            chk({tag, "_wstrb"},  m_WSTRB, 4'hF);
            chk({tag, "_wlast"},  m_WLAST, (i == n - 1));
            @(negedge clk_i);
        end
        wdat_valid = 1'b0;
    endtask

    task automatic read_beats(input int n, input logic [31:0] base, input int stall_at, input string tag);
        int  got = 0;
        int  stall = 0;
        int  cyc = 0;
        bit  stalled = 1'b0;
        while (got < n && cyc < 200) begin
            if (got == stall_at && !stalled && rdat_valid) begin
                stall = 3; stalled = 1'b1;
            end
            rdat_ready = (stall == 0);
            if (stall > 0) stall--;
            #1;
            if (rdat_valid) chk({tag, "_rready_track"}, m_RREADY, rdat_ready);
            if (rdat_valid && rdat_ready) begin
                chk({tag, "_rdata"}, rdat_data, base + 32'(got));
                chk({tag, "_rlast"}, rdat_last, (got == n - 1));
                got++;
            end
            @(negedge clk_i);
            cyc++;
        end
        rdat_ready = 1'b0;
        chk({tag, "_beats"}, got, n);
    endtask

    task automatic wait_rsp(input bit w, input logic [1:0] r, input string tag);
        int cyc = 0;
        while (!rsp_valid && cyc < 50) begin
            @(negedge clk_i); cyc++;
        end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_rsp_write"}, rsp_write, w);
        chk({tag, "_rsp_resp"},  rsp_resp, r);
        @(negedge clk_i);
        chk({tag, "_rsp_pulse"}, rsp_valid, 0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wdat_valid = 1'b0; wdat_data = '0; rdat_ready = 1'b0;
        b_en = 1'b1; err_beat = -1;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_awvalid",   m_AWVALID, 0);
        chk("rst_arvalid",   m_ARVALID, 0);
        chk("rst_wvalid",    m_WVALID, 0);
        chk("rst_awsize",    m_AWSIZE, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdat_valid", rdat_valid, 0);
        rst_n = 1'b1;
        @(negedge clk_i);

        // single write
        send_cmd(1'b1, 20'h00100, 8'd0, 2'd1, "wr1");
        write_beats(1, 32'hDEADBEEF, 1'b0, "wr1");
        wait_rsp(1'b1, RESP_OKAY, "wr1");

        // 8-beat write then read back
        send_cmd(1'b1, 20'h00200, 8'd7, 2'd2, "wr8");
        write_beats(8, 32'h0, 1'b0, "wr8");
        wait_rsp(1'b1, RESP_OKAY, "wr8");
        send_cmd(1'b0, 20'h00200, 8'd7, 2'd3, "rd8");
        read_beats(8, 32'h0, -1, "rd8");
        wait_rsp(1'b0, RESP_OKAY, "rd8");

        // backpressure on both streams
        send_cmd(1'b1, 20'h00300, 8'd5, 2'd0, "wrbp");
        write_beats(6, 32'h50, 1'b1, "wrbp");
        wait_rsp(1'b1, RESP_OKAY, "wrbp");
        send_cmd(1'b0, 20'h00300, 8'd5, 2'd1, "rdbp");
        read_beats(6, 32'h50, 2, "rdbp");
        wait_rsp(1'b0, RESP_OKAY, "rdbp");

        // SLVERR on beat 2 of 4 must stick
        err_beat = 2;
        send_cmd(1'b0, 20'h00200, 8'd3, 2'd2, "rderr");
        read_beats(4, 32'h0, -1, "rderr");
        wait_rsp(1'b0, RESP_SLVERR, "rderr");
        err_beat = -1;

        // command held while the master sits in B
        b_en = 1'b0;
        send_cmd(1'b1, 20'h00600, 8'd0, 2'd1, "busy");
        write_beats(1, 32'hA5A50000, 1'b0, "busy");
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h00600; cmd_len = 8'd0; cmd_id = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("busy_cmd_ready", cmd_ready, 0);
            chk("busy_bready", m_BREADY, 1);
            @(negedge clk_i);
        end
        b_en = 1'b1;
        wait_rsp(1'b1, RESP_OKAY, "busy");
        send_cmd(1'b0, 20'h00600, 8'd0, 2'd2, "busyrd");
        read_beats(1, 32'hA5A50000, -1, "busyrd");
        wait_rsp(1'b0, RESP_OKAY, "busyrd");

        // 4 KB page crossing detection on the command inputs
        cmd_addr = 20'h00FFC; cmd_len = 8'd1;
        #1;
        chk("x4k_cross", dut.cross_4k, 1);
        cmd_addr = 20'h00FF8; cmd_len = 8'd1;
        #1;
        chk("x4k_fits", dut.cross_4k, 0);
        @(negedge clk_i);

        // reset in the middle of a write burst
        send_cmd(1'b1, 20'h00700, 8'd3, 2'd3, "rst");
        wdat_valid = 1'b1; wdat_data = 32'h11;
        @(negedge clk_i);
        #1;
        chk("rst_mid_wvalid", m_WVALID, 1);
        chk("rst_mid_wlast",  m_WLAST, 0);
        @(negedge clk_i);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_now_wvalid",    m_WVALID, 0);
        chk("rst_now_wdata",     m_WDATA, 0);
        chk("rst_now_wdat_ready", wdat_ready, 0);
        chk("rst_now_bready",    m_BREADY, 0);
        chk("rst_now_rsp_valid", rsp_valid, 0);
        wdat_valid = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("rst_rel_cmd_ready", cmd_ready, 1);
        send_cmd(1'b0, 20'h00200, 8'd1, 2'd0, "post");
        read_beats(2, 32'h0, -1, "post");
        wait_rsp(1'b0, RESP_OKAY, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
